// File: rtl/display_scheduler.sv
// display_scheduler: time-shares the seven-segment display path between four
// sources. Round-robin rotation with a fixed dwell per source; source 0
// (alarm/error) preempts. Each source switch is offered with valid/ready.
module display_scheduler #(
  parameter int DATA_W       = 16,
  parameter int DWELL_CYCLES = 40000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] data3,
  input  logic              disp_ready,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  output logic [1:0]        disp_src,
  output logic [3:0]        grant
);

  // Counter holds DWELL_CYCLES-1 down to 0, so clog2 bits are enough.
  localparam int CNT_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHOW} state_t;

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        src_q, src_d;
  logic [3:0]        grant_q, grant_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  dwell_q, dwell_d;

  logic [2:0]        pick;
  logic              take_load;
  logic              go_idle;
  logic [1:0]        load_src;

  // Round-robin search starting one past the last winner; bit 2 = found.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    logic [1:0] win;
    found = 1'b0;
    win   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = p + 2'(k);
      if (!found && r[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  function automatic logic [DATA_W-1:0] sel_data(input logic [1:0] s,
                                                 input logic [DATA_W-1:0] a0,
                                                 input logic [DATA_W-1:0] a1,
                                                 input logic [DATA_W-1:0] a2,
                                                 input logic [DATA_W-1:0] a3);
    case (s)
      2'd0:    return a0;
      2'd1:    return a1;
      2'd2:    return a2;
      default: return a3;
    endcase
  endfunction

  // Next-state and output computation; a new grant is applied in one place.
  always_comb begin
    pick      = rr_pick(req, ptr_q);
    state_d   = state_q;
    ptr_d     = ptr_q;
    src_d     = src_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    data_d    = data_q;
    dwell_d   = dwell_q;
    take_load = 1'b0;
    go_idle   = 1'b0;
    load_src  = pick[1:0];

    case (state_q)
      ST_IDLE: begin
        if (req != 4'b0000) take_load = 1'b1;
      end
      ST_LOAD: begin
        // req changes are ignored here; the handshake always completes.
        if (disp_ready) begin
          state_d = ST_SHOW;
          valid_d = 1'b0;
          dwell_d = DWELL_LOAD;
        end
      end
      ST_SHOW: begin
        data_d  = sel_data(src_q, data0, data1, data2, data3);
        dwell_d = dwell_q - CNT_W'(1);
        if (req[0] && !grant_q[0]) begin
          take_load = 1'b1;
          load_src  = 2'd0;
        end else if (!req[src_q] || (dwell_q == '0)) begin
          if (pick[2]) take_load = 1'b1;
          else         go_idle   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (take_load) begin
      state_d = ST_LOAD;
      ptr_d   = load_src;
      src_d   = load_src;
      grant_d = 4'b0001 << load_src;
      valid_d = 1'b1;
      data_d  = sel_data(load_src, data0, data1, data2, data3);
    end
    if (go_idle) begin
      state_d = ST_IDLE;
      grant_d = 4'b0000;
      valid_d = 1'b0;
      dwell_d = '0;
    end
  end

  // State and output registers; reset acts immediately, even mid-handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd3;
      src_q   <= 2'd0;
      grant_q <= 4'b0000;
      valid_q <= 1'b0;
      data_q  <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      dwell_q <= dwell_d;
    end
  end

  assign disp_valid = valid_q;
  assign disp_data  = data_q;
  assign disp_src   = src_q;
  assign grant      = grant_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Testbench for display_scheduler with an 8-cycle dwell.
module tb_display_scheduler;
  localparam int DATA_W = 16;
  localparam int DWELL  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        req;
  logic [DATA_W-1:0] data0, data1, data2, data3;
  logic              disp_ready;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;
  logic [1:0]        disp_src;
  logic [3:0]        grant;

  int total = 0;
  int bad   = 0;

  display_scheduler #(.DATA_W(DATA_W), .DWELL_CYCLES(DWELL)) dut (
    .clk(clk), .reset(reset), .req(req),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .disp_ready(disp_ready), .disp_valid(disp_valid), .disp_data(disp_data),
    .disp_src(disp_src), .grant(grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]        req;
    logic [DATA_W-1:0] d0, d1, d2, d3;
    logic              rdy;
    logic              ev;
    logic [3:0]        eg;
    logic [1:0]        es;
    logic              cs;
    logic [DATA_W-1:0] ed;
    int                tag;
  } vec_t;

  typedef struct {
    logic              ev;
    logic [3:0]        eg;
    logic [1:0]        es;
    logic              cs;
    logic [DATA_W-1:0] ed;
    int                tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  logic [DATA_W-1:0] cd0, cd1, cd2, cd3;

  task automatic add(input logic [3:0] r, input logic rd, input logic ev,
                     input logic [3:0] eg, input logic [1:0] es, input logic cs,
                     input logic [DATA_W-1:0] ed, input int tag);
    vec_t v;
    v.req = r; v.d0 = cd0; v.d1 = cd1; v.d2 = cd2; v.d3 = cd3; v.rdy = rd;
    v.ev = ev; v.eg = eg; v.es = es; v.cs = cs; v.ed = ed; v.tag = tag;
    vecs.push_back(v);
  endtask

  task automatic check_out(input string nm, input logic ev, input logic [3:0] eg,
                           input logic [1:0] es, input logic cs, input logic [DATA_W-1:0] ed);
    total++;
    if (disp_valid !== ev || grant !== eg || (cs && disp_src !== es) || disp_data !== ed) begin
      bad++;
      $display("FAIL %s: got valid=%b grant=%b src=%0d data=%h, want valid=%b grant=%b src=%0d data=%h",
               nm, disp_valid, grant, disp_src, disp_data, ev, eg, es, ed);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    req = v.req; data0 = v.d0; data1 = v.d1; data2 = v.d2; data3 = v.d3;
    disp_ready = v.rdy;
    sb.push_back('{ev: v.ev, eg: v.eg, es: v.es, cs: v.cs, ed: v.ed, tag: v.tag});
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check_out($sformatf("step%0d_case%0d", idx, e.tag), e.ev, e.eg, e.es, e.cs, e.ed);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t hv;
    cd0 = 16'h0000; cd1 = 16'h1234; cd2 = 16'hABCD; cd3 = 16'h0000;

    // Case 1: idle after reset
    for (int i = 0; i < 20; i++) add(4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1, 16'h0000, 1);

    // Case 2: sources 1 and 2 alternate with an 8-cycle dwell
    add(4'b0110, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 16'h1234, 2);
    for (int i = 0; i < DWELL; i++) add(4'b0110, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1, 16'h1234, 2);
    add(4'b0110, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 16'hABCD, 2);
    for (int i = 0; i < DWELL; i++) add(4'b0110, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 16'hABCD, 2);
    add(4'b0110, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 16'h1234, 2);

    // Case 3: backpressure freezes the offer; source word changes are not taken
    cd1 = 16'h5555;
    for (int i = 0; i < 5; i++) add(4'b0110, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, 16'h1234, 3);
    cd1 = 16'h1234;
    for (int i = 0; i < DWELL; i++) add(4'b0110, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1, 16'h1234, 3);
    add(4'b0110, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 16'hABCD, 3);

    // Case 4: source 0 preempts source 2 in its third SHOW cycle
    for (int i = 0; i < 3; i++) add(4'b0110, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 16'hABCD, 4);
    cd0 = 16'h00E1;
    add(4'b0111, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, 16'h00E1, 4);

    // Case 5: release to source 1, live update, then release to IDLE
    add(4'b0111, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, 16'h00E1, 5);
    cd1 = 16'h0010;
    add(4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 16'h0010, 5);
    add(4'b0010, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1, 16'h0010, 5);
    cd1 = 16'h0011;
    add(4'b0010, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1, 16'h0011, 5);
    add(4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 16'h0011, 5);
    add(4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 16'h0011, 5);

    // Reset state
    reset = 1'b1; req = 4'b0000; disp_ready = 1'b0;
    data0 = '0; data1 = '0; data2 = '0; data3 = '0;
    #12;
    check_out("reset_state", 1'b0, 4'b0000, 2'd0, 1'b1, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Case 6: asynchronous reset during a stalled handshake
    cd3 = 16'h3333;
    hv = '{req: 4'b0100, d0: cd0, d1: cd1, d2: cd2, d3: cd3, rdy: 1'b0,
           ev: 1'b1, eg: 4'b0100, es: 2'd2, cs: 1'b1, ed: 16'hABCD, tag: 6};
    apply(hv, 100);
    #2 reset = 1'b1;
    #1 check_out("async_reset_immediate", 1'b0, 4'b0000, 2'd0, 1'b1, 16'h0000);
    @(posedge clk);
    #1 check_out("reset_held_over_edge", 1'b0, 4'b0000, 2'd0, 1'b1, 16'h0000);
    @(negedge clk);
    req = 4'b0000;
    reset = 1'b0;
    hv = '{req: 4'b1000, d0: cd0, d1: cd1, d2: cd2, d3: cd3, rdy: 1'b0,
           ev: 1'b1, eg: 4'b1000, es: 2'd3, cs: 1'b1, ed: 16'h3333, tag: 6};
    apply(hv, 101);
    hv.rdy = 1'b1; hv.ev = 1'b0;
    apply(hv, 102);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Time-shares the 16-bit seven-segment display path between four requesting sources.
- Sources include the parking timer, FSM state code, free-slot count and error code.
- Round-robin rotation with a fixed dwell time per source; source 0 (alarm/error) may preempt.
- Sits between the producers and the display mux/driver. Each source switch is delivered with a valid/ready handshake.

Parameters:
- DATA_W, 16, width of each source word and of disp_data.
- DWELL_CYCLES, 40000000, clk cycles a granted source stays on display (1 s at 40 MHz). Legal values are ≥ 2.

Ports:
- clk  in  1  system clock, 40 MHz.
- reset  in  1  asynchronous, active-high.
- req  in  4  per-source display request, level-sensitive; bit i belongs to source i.
- data0  in  DATA_W  source 0 word (alarm/error, urgent).
- data1  in  DATA_W  source 1 word.
- data2  in  DATA_W  source 2 word.
- data3  in  DATA_W  source 3 word.
- disp_ready  in  1  display accepts a new source this cycle.
- disp_valid  out  1  new source word offered to the display.
- disp_data  out  DATA_W  word to display.
- disp_src  out  2  index of the granted source.
- grant  out  4  one-hot grant; all zero when idle.

Behaviour:
- Clock and reset: clk is the clock. reset is asynchronous, active-high.
  - Reset forces state IDLE, disp_valid=0, disp_data=0, disp_src=0, grant=0, dwell counter 0.
  - Reset sets the round-robin pointer to 3, so source 0 wins the first search.
  - Reset asserted in any state, mid-handshake included, takes effect immediately with no completion.
- States: IDLE, LOAD, SHOW.
- Round-robin select:
  - Search starts at ptr+1 and proceeds upward mod 4; the first asserted req bit wins.
  - ptr updates to the winner on entry to LOAD.
- IDLE:
  - grant=0, disp_valid=0, disp_data holds its last value.
  - If req≠0 at a clk edge, go to LOAD at that edge. At the same edge register disp_src and grant for the winner, disp_data=data[winner], disp_valid=1.
  - Latency from req rising to disp_valid high is 1 cycle.
- LOAD:
  - disp_valid=1; disp_data, disp_src and grant are frozen.
  - When disp_valid & disp_ready at an edge: go to SHOW, disp_valid→0, load the dwell counter with DWELL_CYCLES-1.
  - While disp_ready=0, wait indefinitely. The dwell counter does not run.
  - Changes on req are ignored in LOAD; the handshake always completes, even if the granted source drops req.
- SHOW:
  - disp_data follows data[disp_src] with 1-cycle registered latency (live update, e.g. the timer counting). disp_valid stays 0.
  - The dwell counter decrements each cycle. Events are evaluated at each edge in this priority order:
    1. req[0]=1 and grant≠source 0: preempt. Go to LOAD with source 0 immediately, regardless of remaining dwell. Set ptr=0.
    2. Granted source's req=0: go to LOAD with the RR winner, or to IDLE if req=0.
    3. Counter=0 (dwell expired): go to LOAD with the RR winner. If the current source is the only requester it is re-granted, giving a new handshake and a refreshed word. If req=0, go to IDLE.
  - Total SHOW time without events is exactly DWELL_CYCLES cycles.
- Simultaneous events:
  - Preemption has priority over expiry and over release.
  - A request arriving in the same cycle as expiry takes part in that cycle's RR search.
- Invariants:
  - grant is one-hot in LOAD and SHOW, and zero in IDLE.
  - disp_valid is 1 only in LOAD.
  - grant equals 1<<disp_src whenever non-zero.

Test Plan:
1. Reset with req=0000 and 20 cycles of idle clocking → disp_valid=0, disp_data=0x0000, grant=0000, disp_src=0 throughout.
2. DWELL_CYCLES=8, disp_ready=1, req=0110, data1=0x1234, data2=0xABCD → grant alternates 0010/0100. Each SHOW lasts 8 cycles; disp_data shows 0x1234 then 0xABCD; one 1-cycle disp_valid pulse per switch; first valid 1 cycle after req.
3. Backpressure: disp_ready=0 for 5 cycles after disp_valid rises → disp_valid, disp_data and grant stay stable. SHOW starts only after the edge where disp_ready=1, and the full 8-cycle dwell follows.
4. Preemption: source 2 in SHOW at dwell cycle 3, req[0] asserted with data0=0x00E1 → next edge gives disp_valid=1, grant=0001, disp_data=0x00E1.
5. Live update and release: source 1 in SHOW, data1 steps 0x0010→0x0011 → disp_data=0x0011 one cycle later with disp_valid=0. Then req=0000 → next edge enters IDLE, grant=0000, disp_data stays 0x0011.
6. Async reset pulse in LOAD, mid-handshake → outputs reach their reset values before the next clk edge. After release, req=1000 → grant=1000 with disp_valid=1 one cycle later.
